// File: rtl/fetch_stage_pkg.sv
// Shared constants for the fetch stage and its neighbours in the MIPS pipeline:
// instruction encodings, default widths and instruction field positions.
package fetch_stage_pkg;
    localparam int NB_DATA_DEF = 32;
    localparam int NB_ADDR_DEF = 10;

    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    // Field positions of a MIPS instruction word; decode slices with these too.
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
endpackage

// File: rtl/fetch_stage_if.sv
// Signal bundle between the fetch stage and its controllers (debug unit,
// hazard unit, branch/jump logic) plus the outputs toward decode.
interface fetch_stage_if
    import fetch_stage_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_ADDR = NB_ADDR_DEF
);
    // i_valid is a step enable, not a handshake: the stage acts on an edge only
    // when i_valid=1 and holds every register otherwise; there is no ready.
    logic               i_valid;
    logic               i_stall;
    logic               i_jump;
    logic [NB_DATA-1:0] i_jump_target;
    logic               i_branch_taken;
    logic [NB_DATA-1:0] i_branch_target;
    logic               i_mem_write_enable;
    logic [NB_ADDR-1:0] i_mem_write_addr;
    logic [NB_DATA-1:0] i_mem_write_data;
    logic [NB_DATA-1:0] o_instruction;
    logic [NB_DATA-1:0] o_pc_next;
    logic [NB_DATA-1:0] o_pc;
    logic               o_halt;

    modport master (
        output i_valid, i_stall, i_jump, i_jump_target,
               i_branch_taken, i_branch_target,
               i_mem_write_enable, i_mem_write_addr, i_mem_write_data,
        input  o_instruction, o_pc_next, o_pc, o_halt
    );

    modport slave (
        input  i_valid, i_stall, i_jump, i_jump_target,
               i_branch_taken, i_branch_target,
               i_mem_write_enable, i_mem_write_addr, i_mem_write_data,
        output o_instruction, o_pc_next, o_pc, o_halt
    );
endinterface

// File: rtl/instruction_memory.sv
// Word-addressed instruction store: one asynchronous read port, one
// synchronous write port. Contents survive reset so a program can be re-run.
module instruction_memory #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 10
) (
    input  logic               clk,
    input  logic               write_enable,
    input  logic [NB_ADDR-1:0] write_addr,
    input  logic [NB_DATA-1:0] write_data,
    input  logic [NB_ADDR-1:0] read_addr,
    output logic [NB_DATA-1:0] read_data
);
    logic [NB_DATA-1:0] mem [2**NB_ADDR];

    always_ff @(posedge clk) begin
        if (write_enable) begin
            mem[write_addr] <= write_data;
        end
    end

    // Combinational read sees the pre-edge word when read and write collide.
    assign read_data = mem[read_addr];
endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection with redirect,
// stall and HALT handling, feeding {instruction, PC+1} to decode.
module fetch_stage #(
    parameter int                  NB_DATA   = fetch_stage_pkg::NB_DATA_DEF,
    parameter int                  NB_ADDR   = fetch_stage_pkg::NB_ADDR_DEF,
    parameter logic [NB_DATA-1:0]  HALT_WORD = fetch_stage_pkg::HALT_WORD
) (
    input  logic        i_clock,
    input  logic        i_reset,
    fetch_stage_if.slave bus
);
    import fetch_stage_pkg::NOP_WORD;

    localparam logic [NB_DATA-1:0] NOP = NB_DATA'(NOP_WORD);

    logic [NB_DATA-1:0] pc;
    logic [NB_DATA-1:0] pc_plus_one;
    logic [NB_DATA-1:0] instruction;
    logic [NB_DATA-1:0] pc_next;
    logic               halt;
    logic [NB_DATA-1:0] fetched;
    logic               mem_we;

    // Program loading is only allowed while the pipeline is frozen.
    assign mem_we      = bus.i_mem_write_enable & ~bus.i_valid;
    assign pc_plus_one = pc + 1'b1;

    instruction_memory #(
        .NB_DATA (NB_DATA),
        .NB_ADDR (NB_ADDR)
    ) u_imem (
        .clk          (i_clock),
        .write_enable (mem_we),
        .write_addr   (bus.i_mem_write_addr),
        .write_data   (bus.i_mem_write_data),
        .read_addr    (pc[NB_ADDR-1:0]),
        .read_data    (fetched)
    );

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            pc          <= '0;
            instruction <= NOP;
            pc_next     <= '0;
            halt        <= 1'b0;
        end else if (bus.i_valid) begin
            if (halt) begin
                // Drain the downstream stages with bubbles; pc and pc_next freeze.
                instruction <= NOP;
            end else if (bus.i_jump) begin
                pc          <= bus.i_jump_target;
                instruction <= NOP;
                pc_next     <= pc_plus_one;
            end else if (bus.i_branch_taken) begin
                pc          <= bus.i_branch_target;
                instruction <= NOP;
                pc_next     <= pc_plus_one;
            end else if (!bus.i_stall) begin
                instruction <= fetched;
                pc_next     <= pc_plus_one;
                if (fetched == HALT_WORD) begin
                    halt <= 1'b1;
                end else begin
                    pc <= pc_plus_one;
                end
            end
        end
    end

    assign bus.o_instruction = instruction;
    assign bus.o_pc_next     = pc_next;
    assign bus.o_pc          = pc;
    assign bus.o_halt        = halt;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: program load, sequential fetch, stall,
// redirects and their priority, HALT, load gating, wrap and async reset.
module tb_fetch_stage;
    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;

    fetch_stage_if #(.NB_DATA(32), .NB_ADDR(10)) bus ();

    fetch_stage dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [31:0] instr,
                             input logic [31:0] pcn, input logic [31:0] pc);
        check({tag, ".instr"},   bus.o_instruction, instr);
        check({tag, ".pc_next"}, bus.o_pc_next,     pcn);
        check({tag, ".pc"},      bus.o_pc,          pc);
    endtask

    task automatic load(input logic [9:0] addr, input logic [31:0] data);
        bus.i_mem_write_enable = 1'b1;
        bus.i_mem_write_addr   = addr;
        bus.i_mem_write_data   = data;
        step();
        bus.i_mem_write_enable = 1'b0;
    endtask

    task automatic clear_ctrl();
        bus.i_stall        = 1'b0;
        bus.i_jump         = 1'b0;
        bus.i_branch_taken = 1'b0;
    endtask

    initial begin
        pass_cnt               = 0;
        total_cnt              = 0;
        rst                    = 1'b1;
        bus.i_valid            = 1'b0;
        bus.i_stall            = 1'b0;
        bus.i_jump             = 1'b0;
        bus.i_jump_target      = '0;
        bus.i_branch_taken     = 1'b0;
        bus.i_branch_target    = '0;
        bus.i_mem_write_enable = 1'b0;
        bus.i_mem_write_addr   = '0;
        bus.i_mem_write_data   = '0;

        #2;
        check_out("reset", 32'h0, 32'h0, 32'h0);
        check("reset.halt", {31'b0, bus.o_halt}, 32'h0);
        rst = 1'b0;

        load(10'd0,    32'h2001_0005);
        load(10'd1,    32'h2002_0007);
        load(10'd2,    32'h0022_1820);
        load(10'd3,    32'hFFFF_FFFF);
        load(10'd4,    32'h0000_0044);
        load(10'd5,    32'h0000_0055);
        load(10'd8,    32'h2003_0008);
        load(10'd16,   32'h2004_0010);
        load(10'd1023, 32'h1234_5678);
        check_out("load_hold", 32'h0, 32'h0, 32'h0);

        // Sequential fetch with a 3-cycle stall at pc=2.
        bus.i_valid = 1'b1;
        step(); check_out("fetch0", 32'h2001_0005, 32'd1, 32'd1);
        step(); check_out("fetch1", 32'h2002_0007, 32'd2, 32'd2);
        bus.i_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); check_out("stall", 32'h2002_0007, 32'd2, 32'd2);
        end
        bus.i_stall = 1'b0;
        step(); check_out("fetch2", 32'h0022_1820, 32'd3, 32'd3);
        check("pre_halt", {31'b0, bus.o_halt}, 32'h0);
        step(); check_out("fetch_halt", 32'hFFFF_FFFF, 32'd4, 32'd3);
        check("halt_set", {31'b0, bus.o_halt}, 32'h1);
        bus.i_jump        = 1'b1;
        bus.i_jump_target = 32'd16;
        step(); check_out("after_halt", 32'h0, 32'd4, 32'd3);
        check("halt_sticky", {31'b0, bus.o_halt}, 32'h1);
        clear_ctrl();

        // Asynchronous reset between edges, then re-run without reload.
        #2;
        rst = 1'b1;
        #1;
        check_out("async_rst", 32'h0, 32'h0, 32'h0);
        check("async_rst.halt", {31'b0, bus.o_halt}, 32'h0);
        rst = 1'b0;
        step(); check_out("rerun0", 32'h2001_0005, 32'd1, 32'd1);

        bus.i_jump        = 1'b1;
        bus.i_jump_target = 32'd4;
        step(); check_out("jump4", 32'h0, 32'd2, 32'd4);
        clear_ctrl();
        bus.i_branch_taken  = 1'b1;
        bus.i_branch_target = 32'd8;
        step(); check_out("branch8", 32'h0, 32'd5, 32'd8);
        clear_ctrl();
        step(); check_out("fetch8", 32'h2003_0008, 32'd9, 32'd9);

        // Jump beats branch beats stall.
        bus.i_jump          = 1'b1;
        bus.i_jump_target   = 32'd16;
        bus.i_branch_taken  = 1'b1;
        bus.i_branch_target = 32'd8;
        bus.i_stall         = 1'b1;
        step(); check_out("prio", 32'h0, 32'd10, 32'd16);
        clear_ctrl();
        step(); check_out("fetch16", 32'h2004_0010, 32'd17, 32'd17);

        // Program-load write is ignored while i_valid=1.
        bus.i_jump             = 1'b1;
        bus.i_jump_target      = 32'd5;
        bus.i_mem_write_enable = 1'b1;
        bus.i_mem_write_addr   = 10'd5;
        bus.i_mem_write_data   = 32'hDEAD_BEEF;
        step(); check_out("jump5", 32'h0, 32'd18, 32'd5);
        clear_ctrl();
        bus.i_mem_write_enable = 1'b0;
        step(); check_out("wr_ignored", 32'h0000_0055, 32'd6, 32'd6);

        // With i_valid=0 the write lands and control inputs are ignored.
        bus.i_valid            = 1'b0;
        bus.i_mem_write_enable = 1'b1;
        bus.i_stall            = 1'b1;
        bus.i_jump             = 1'b1;
        bus.i_jump_target      = 32'd0;
        step(); check_out("frozen", 32'h0000_0055, 32'd6, 32'd6);
        clear_ctrl();
        bus.i_mem_write_enable = 1'b0;
        bus.i_valid            = 1'b1;
        bus.i_jump             = 1'b1;
        bus.i_jump_target      = 32'd5;
        step(); check_out("rejump5", 32'h0, 32'd7, 32'd5);
        clear_ctrl();
        step(); check_out("wr_taken", 32'hDEAD_BEEF, 32'd6, 32'd6);

        // Index aliasing and full-width pc wrap.
        bus.i_jump        = 1'b1;
        bus.i_jump_target = 32'h0000_0400;
        step(); check_out("jump400", 32'h0, 32'd7, 32'h0000_0400);
        clear_ctrl();
        step(); check_out("alias0", 32'h2001_0005, 32'h0000_0401, 32'h0000_0401);
        bus.i_jump        = 1'b1;
        bus.i_jump_target = 32'hFFFF_FFFF;
        step(); check_out("jump_top", 32'h0, 32'h0000_0402, 32'hFFFF_FFFF);
        clear_ctrl();
        step(); check_out("wrap", 32'h1234_5678, 32'h0, 32'h0);

        // HALT word under stall or redirect does not halt.
        bus.i_jump        = 1'b1;
        bus.i_jump_target = 32'd3;
        step(); check_out("jump3", 32'h0, 32'd1, 32'd3);
        clear_ctrl();
        bus.i_stall = 1'b1;
        step(); check_out("stall_at_halt", 32'h0, 32'd1, 32'd3);
        check("stall_no_halt", {31'b0, bus.o_halt}, 32'h0);
        clear_ctrl();
        bus.i_branch_taken  = 1'b1;
        bus.i_branch_target = 32'd0;
        step(); check_out("squash_halt", 32'h0, 32'd4, 32'd0);
        check("squash_no_halt", {31'b0, bus.o_halt}, 32'h0);
        clear_ctrl();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the MIPS pipeline, directly upstream of the decode stage.
- Holds the program counter and a word-addressed instruction memory that the debug unit loads before a run.
- Each advancing cycle it presents {instruction, PC+1} to decode.
- Handles stall from the hazard unit, branch/jump redirect, and HALT detection.

Parameters:
- NB_DATA, 32, data/instruction/PC width.
- NB_ADDR, 10, instruction memory address width (depth = 2^NB_ADDR words).
- HALT_WORD, 32'hFFFF_FFFF, encoding of the HALT instruction.

Ports:
- i_clock  in  1  clock, rising-edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_valid  in  1  pipeline step enable from the debug unit; 0 freezes the stage.
- i_stall  in  1  hazard unit: hold PC and outputs.
- i_jump  in  1  redirect to i_jump_target.
- i_jump_target  in  NB_DATA  absolute word address.
- i_branch_taken  in  1  redirect to i_branch_target.
- i_branch_target  in  NB_DATA  absolute word address.
- i_mem_write_enable  in  1  program-load write strobe.
- i_mem_write_addr  in  NB_ADDR  program-load word address.
- i_mem_write_data  in  NB_DATA  program-load word.
- o_instruction  out  NB_DATA  fetched instruction, to decode i_instruction.
- o_pc_next  out  NB_DATA  PC+1 of the fetched instruction, to decode i_pc_next.
- o_pc  out  NB_DATA  current PC, for the debug unit.
- o_halt  out  1  sticky: HALT has been fetched.

Behaviour:
- Reset, asynchronous, effective immediately:
  - pc=0, o_instruction=0 (NOP), o_pc_next=0, o_halt=0.
  - Memory contents are not cleared.
- Advance condition: adv = i_valid & ~o_halt.
- Per rising edge when adv, in priority order:
  1. i_jump: pc<=i_jump_target; o_instruction<=0; o_pc_next<=pc+1.
  2. else i_branch_taken: pc<=i_branch_target; o_instruction<=0; o_pc_next<=pc+1.
  3. else i_stall: pc, o_instruction and o_pc_next hold.
  4. else:
     - o_instruction<=mem[pc[NB_ADDR-1:0]]; o_pc_next<=pc+1; pc<=pc+1.
     - If the fetched word == HALT_WORD: o_halt<=1 and pc holds (pc is not incremented).
- Redirect priority:
  - Redirect beats stall: the hazard is moot on the wrong path.
  - Jump beats branch when both are asserted.
- The wrong-path fetch in a redirect cycle is squashed to NOP (one bubble).
- HALT is detected only on a non-squashed, non-stalled fetch.
- After HALT:
  - o_halt stays 1 until reset.
  - pc freezes at the HALT address.
  - Subsequent edges force o_instruction<=0 so downstream stages drain with NOPs; o_pc_next holds.
- Latency: mem[pc] appears on o_instruction one rising edge after pc shows it (o_pc is combinational from the pc register).
- Memory:
  - Asynchronous read, synchronous write on rising edge.
  - Write happens only when i_mem_write_enable & ~i_valid; writes while i_valid=1 are ignored.
  - Read and write to the same address in one cycle: read returns the old word.
- Width and wrap:
  - pc+1 is computed at NB_DATA bits and wraps modulo 2^NB_DATA.
  - The memory index uses the low NB_ADDR bits, so pc=2^NB_ADDR aliases address 0.
  - Upper target bits are kept in pc and o_pc_next.
- i_valid=0: everything holds, including o_halt; stall and redirect inputs are ignored.
- Reset mid-run: PC returns to 0 and the program stays loaded, so a re-run needs no reload.

Decomposition:
- Shared package:
  - NOP_WORD (32'h0) and HALT_WORD.
  - NB_DATA and NB_ADDR defaults.
  - Opcode field position constants, also used by decode.
- One sub-module: instruction_memory.
  - Parameterised NB_DATA/NB_ADDR.
  - Single async read port and single sync write port.
- PC/next-PC select logic stays in fetch_stage.

Test Plan:
- Load mem[0..3]={32'h2001_0005, 32'h2002_0007, 32'h0022_1820, HALT}, then i_valid=1 -> o_instruction sequence 20010005/20020007/00221820/FFFFFFFF with o_pc_next 1,2,3,4. o_halt rises with the HALT fetch; o_pc stays 3; o_instruction=0 thereafter.
- Stall held 3 cycles at pc=2 -> o_pc=2, o_instruction and o_pc_next unchanged for 3 edges, then resume with mem[2].
- i_branch_taken=1, target=8, at pc=4 -> next o_instruction=0, o_pc=8; the following edge gives mem[8] with o_pc_next=9.
- i_jump (target 16) and i_branch_taken (target 8) together, with i_stall=1 -> o_pc=16 and a NOP is output (jump beats branch and stall).
- Write mem[5] while i_valid=1 -> mem[5] unchanged on later fetch; the same write with i_valid=0 takes effect.
- Assert i_reset asynchronously mid-run (between edges) -> o_pc=0, o_halt=0, o_instruction=0 immediately; after release, the program re-executes from mem[0] without reload.
